// File: rtl/counter_job_scheduler_if.sv
// Requester-side job bus and counter-control bus for counter_job_scheduler.
// The scheduler connects through the slave modport; the environment drives through master.
interface counter_job_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] start_val;
    logic [NUM_REQ*WIDTH-1:0] end_val;
    logic [WIDTH-1:0]         cnt_q;
    logic                     cnt_load;
    logic [WIDTH-1:0]         cnt_data;
    logic                     cnt_inc;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;

    modport master (
        output req, start_val, end_val, cnt_q,
        input  cnt_load, cnt_data, cnt_inc, grant, done, busy
    );

    modport slave (
        input  req, start_val, end_val, cnt_q,
        output cnt_load, cnt_data, cnt_inc, grant, done, busy
    );
endinterface

// File: rtl/counter_job_scheduler.sv
// Round-robin scheduler sharing one external loadable up-counter among NUM_REQ requesters.
// One job at a time: load start value, increment until the counter equals the end value, pulse done.
module counter_job_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    counter_job_scheduler_if.slave   bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t                         state, state_nxt;
    logic [PW-1:0]                  ptr, win, cand;
    logic                           found;
    logic [WIDTH-1:0]               s_q, e_q;
    logic [NUM_REQ-1:0]             grant_q;
    logic [NUM_REQ-1:0][WIDTH-1:0]  start_arr, end_arr;

    assign start_arr = bus.start_val;
    assign end_arr   = bus.end_val;

    // First set request searching upward from ptr+1 with wrap; ptr itself is checked last.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        cand  = ptr;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = PW'((int'(ptr) + i) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     if (bus.cnt_q == e_q) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ptr     <= PW'(NUM_REQ - 1);
            s_q     <= '0;
            e_q     <= '0;
            grant_q <= '0;
        end else begin
            state <= state_nxt;
            // Job inputs are captured only here; later changes to req/start/end are ignored.
            if (state == IDLE && found) begin
                ptr     <= win;
                s_q     <= start_arr[win];
                e_q     <= end_arr[win];
                grant_q <= NUM_REQ'(1) << win;
            end else if (state == DONE) begin
                grant_q <= '0;
            end
        end
    end

    assign bus.cnt_load = (state == LOAD);
    assign bus.cnt_data = s_q;
    assign bus.cnt_inc  = (state == RUN) && (bus.cnt_q != e_q);
    assign bus.grant    = grant_q;
    assign bus.done     = (state == DONE) ? grant_q : '0;
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_counter_job_scheduler.sv
// Bench for counter_job_scheduler: external counter model, scoreboard of expected jobs,
// a table of job vectors and hand-written multi-cycle sequences.
module tb_counter_job_scheduler;
    localparam int NR = 4;
    localparam int W  = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    counter_job_scheduler_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

    counter_job_scheduler #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [NR-1:0]        req_v = '0;
    logic [NR-1:0][W-1:0] sv = '0;
    logic [NR-1:0][W-1:0] ev = '0;
    logic [W-1:0]         cnt = '0;

    assign bus.req       = req_v;
    assign bus.start_val = sv;
    assign bus.end_val   = ev;
    assign bus.cnt_q     = cnt;

    // External counter: load beats inc, not affected by scheduler reset.
    always @(posedge clk) begin
        if (bus.cnt_load)     cnt <= bus.cnt_data;
        else if (bus.cnt_inc) cnt <= cnt + 4'd1;
    end

    typedef struct {
        logic [3:0] req;
        logic [3:0] s;
        logic [3:0] e;
        logic [3:0] grant;
    } vec_t;

    typedef struct {
        logic [3:0] grant;
        logic [3:0] s;
        logic [3:0] e;
        int         k;
    } sb_t;

    sb_t sb[$];
    int  errors = 0;
    int  checks = 0;
    int  inc_seen = 0;
    int  since_load = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [3:0] g, input logic [3:0] s, input logic [3:0] e);
        sb_t t;
        t.grant = g;
        t.s     = s;
        t.e     = e;
        t.k     = int'(4'(e - s));
        sb.push_back(t);
    endtask

    // Scoreboard monitor: checks each load against the queue head and retires it on done.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.cnt_load) begin
                chk("load_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    chk("load_grant", int'(bus.grant), int'(sb[0].grant));
                    chk("load_data", int'(bus.cnt_data), int'(sb[0].s));
                end
                inc_seen   = 0;
                since_load = 0;
            end else begin
                since_load++;
            end
            if (bus.cnt_inc) inc_seen++;
            if (bus.done != '0) begin
                chk("done_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    sb_t t;
                    t = sb.pop_front();
                    chk("done_onehot", int'(bus.done), int'(t.grant));
                    chk("done_grant", int'(bus.grant), int'(t.grant));
                    chk("inc_cycles", inc_seen, t.k);
                    chk("done_latency", since_load, 2 + t.k);
                    chk("done_cnt_q", int'(cnt), int'(t.e));
                end
            end
        end
    end

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!bus.busy && sb.size() == 0) return;
        end
        chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic wait_load(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (bus.cnt_load) return;
        end
        chk("wait_load_timeout", 1, 0);
    endtask

    task automatic do_reset();
        req_v = '0;
        reset_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_grant"}, int'(bus.grant), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_load"}, int'(bus.cnt_load), 0);
        chk({tag, "_inc"}, int'(bus.cnt_inc), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_data"}, int'(bus.cnt_data), 0);
    endtask

    vec_t vecs[8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_c;
        int loads;
        int hit;

        // Pointer starts at NUM_REQ-1; each row's expected grant follows the previous winner.
        vecs[0] = '{4'b0001, 4'd3,  4'd7,  4'b0001};
        vecs[1] = '{4'b0100, 4'd9,  4'd9,  4'b0100};
        vecs[2] = '{4'b0010, 4'd14, 4'd1,  4'b0010};
        vecs[3] = '{4'b1001, 4'd5,  4'd6,  4'b1000};
        vecs[4] = '{4'b0011, 4'd15, 4'd15, 4'b0001};
        vecs[5] = '{4'b0101, 4'd0,  4'd15, 4'b0100};
        vecs[6] = '{4'b1011, 4'd8,  4'd2,  4'b1000};
        vecs[7] = '{4'b0110, 4'd7,  4'd8,  4'b0010};

        #2 check_quiet("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Cycle-exact single job: req=0001, S=3, E=7.
        @(posedge clk);
        #1;
        sv[0] = 4'd3; ev[0] = 4'd7; req_v = 4'b0001;
        push_exp(4'b0001, 4'd3, 4'd7);
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            chk("seqA_busy",  int'(bus.busy),     int'(c >= 1 && c <= 7));
            chk("seqA_grant", int'(bus.grant),    (c >= 1 && c <= 7) ? 1 : 0);
            chk("seqA_load",  int'(bus.cnt_load), int'(c == 1));
            chk("seqA_inc",   int'(bus.cnt_inc),  int'(c >= 2 && c <= 5));
            chk("seqA_done",  int'(bus.done),     (c == 7) ? 1 : 0);
            if (c >= 2 && c <= 6) chk("seqA_cnt_q", int'(cnt), 3 + c - 2);
            if (c == 1) req_v = '0;
        end
        wait_idle(10);

        // Table of jobs, including zero-length, wrap-around and contended requests.
        do_reset();
        for (int v = 0; v < 8; v++) begin
            @(posedge clk);
            #1;
            for (int j = 0; j < NR; j++) begin
                sv[j] = vecs[v].grant[j] ? vecs[v].s : 4'(vecs[v].s + j + 3);
                ev[j] = vecs[v].grant[j] ? vecs[v].e : 4'(vecs[v].e + j + 5);
            end
            req_v = vecs[v].req;
            push_exp(vecs[v].grant, vecs[v].s, vecs[v].e);
            wait_load(5);
            req_v = '0;
            wait_idle(40);
        end

        // Job inputs change after grant: request dropped and end value raised at cycle 2.
        @(posedge clk);
        #1;
        sv[3] = 4'd2; ev[3] = 4'd5; req_v = 4'b1000;
        push_exp(4'b1000, 4'd2, 4'd5);
        done_c = -1;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c == 2) begin
                req_v = '0;
                ev[3] = 4'd15;
            end
            if (bus.done != '0 && done_c < 0) done_c = c;
        end
        chk("seqB_done_cycle", done_c, 6);
        wait_idle(10);

        // Round-robin fairness with all four requesting continuously.
        do_reset();
        for (int j = 0; j < NR; j++) begin
            sv[j] = 4'd0;
            ev[j] = 4'd1;
        end
        push_exp(4'b0001, 4'd0, 4'd1);
        push_exp(4'b0010, 4'd0, 4'd1);
        push_exp(4'b0100, 4'd0, 4'd1);
        push_exp(4'b1000, 4'd0, 4'd1);
        push_exp(4'b0001, 4'd0, 4'd1);
        req_v = 4'b1111;
        loads = 0;
        for (int c = 0; c < 100 && loads < 5; c++) begin
            @(negedge clk);
            if (bus.cnt_load) loads++;
        end
        req_v = '0;
        chk("rr_loads", loads, 5);
        wait_idle(20);

        // Reset in the middle of a run, then confirm the pointer is back to NUM_REQ-1.
        @(posedge clk);
        #1;
        sv[0] = 4'd0; ev[0] = 4'd10; req_v = 4'b0001;
        push_exp(4'b0001, 4'd0, 4'd10);
        wait_load(5);
        req_v = '0;
        hit = 0;
        for (int c = 0; c < 20 && hit == 0; c++) begin
            @(negedge clk);
            if (bus.cnt_inc && cnt == 4'd4) hit = 1;
        end
        chk("rst_reached_cnt4", hit, 1);
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1 check_quiet("rst_mid");
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_hold_done", int'(bus.done), 0);
            chk("rst_hold_busy", int'(bus.busy), 0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sv[0] = 4'd1; ev[0] = 4'd2;
        sv[3] = 4'd7; ev[3] = 4'd8;
        req_v = 4'b1001;
        push_exp(4'b0001, 4'd1, 4'd2);
        wait_load(5);
        chk("rst_after_grant", int'(bus.grant), 1);
        req_v = '0;
        wait_idle(20);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/counter_job_scheduler.md
Name: counter_job_scheduler

Overview:
Round-robin scheduler that shares one loadable WIDTH-bit up-counter among NUM_REQ requesters. Each requester submits a count job (start value, end value). The scheduler grants one job at a time, loads the counter, increments it until it reaches the end value, then pulses a per-requester done. The counter itself is external; this block drives its load and increment controls and watches its value.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 4, counter width in bits; all arithmetic is modulo 2^WIDTH

Ports:
- clk  input  1  clock
- reset_n  input  1  reset: asynchronous, active-low
- req  input  NUM_REQ  per-requester job request (level)
- start_val  input  NUM_REQ*WIDTH  packed start values; slice i belongs to requester i
- end_val  input  NUM_REQ*WIDTH  packed end values; slice i belongs to requester i
- cnt_q  input  WIDTH  current value of the external counter
- cnt_load  output  1  counter loads cnt_data at the next edge
- cnt_data  output  WIDTH  load value for the counter
- cnt_inc  output  1  counter increments by 1 (mod 2^WIDTH) at the next edge; cnt_load has priority
- grant  output  NUM_REQ  one-hot owner of the counter; all zero when idle
- done  output  NUM_REQ  one-cycle one-hot completion pulse
- busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset values:
  - state = IDLE.
  - grant, done, cnt_load, cnt_inc, busy = 0; cnt_data = 0.
  - Round-robin pointer = NUM_REQ-1, so req[0] has top priority first.
- Reset mid-job: abandons the job immediately, with no done pulse. The pointer is restored to NUM_REQ-1.
- FSM has four states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If req is nonzero, choose the winner w: the first set req bit searching upward (with wrap) from pointer+1.
  - Latch start_val[w] and end_val[w] into internal registers S and E.
  - Set pointer = w and go to LOAD.
  - If req is zero, stay in IDLE.
- LOAD: cnt_load=1, cnt_data=S, cnt_inc=0. Go to RUN.
- RUN:
  - If cnt_q != E: cnt_inc=1 and stay in RUN.
  - If cnt_q == E: cnt_inc=0 and go to DONE.
- DONE: done[w]=1 for exactly this cycle. Go to IDLE.
- grant[w] is registered:
  - High in every cycle the state is LOAD, RUN or DONE.
  - Drops in the cycle the state returns to IDLE.
- Outputs are Moore decodes of state and latched registers only; there is no combinational path from req or start_val to any output.
- cnt_data holds S outside LOAD (it is don't-care to the counter).
- Latency: req seen in IDLE at cycle 0 gives:
  - grant and cnt_load at cycle 1;
  - RUN from cycle 2;
  - k = (E - S) mod 2^WIDTH increment cycles;
  - done at cycle 3+k.
- Wrap-around: if E < S, the count passes through 2^WIDTH-1 to 0 and continues to E.
- S == E: zero increments; done at cycle 3.
- Job inputs are sampled only in IDLE. Changes to start_val, end_val or req[w] after grant are ignored, and a dropped request still completes.
- Back-to-back jobs: req still high in IDLE after DONE is eligible again. Because the pointer has advanced, other pending requesters win first.
- Minimum gap between jobs: one IDLE cycle.
- External counter contract used by the bench model: load beats inc, and cnt_q updates on the same edge.

Test Plan:
- Single job: req=0001, S=3, E=7 -> grant=0001 at cycles 1..7; cnt_load at cycle 1 with cnt_data=3; cnt_inc high at cycles 2..5; done[0] at cycle 7; busy low at cycle 8.
- Zero-length job: req=0100, S=E=9 -> cnt_inc never asserted; done[2] at cycle 3; grant=0100 at cycles 1..3.
- Wrap-around: req=0010, S=14, E=1 -> cnt_q sequence 14,15,0,1; cnt_inc for exactly 3 cycles; done[1] at cycle 6.
- Round-robin fairness: req=1111 held, every job S=0, E=1 -> grant order 0001, 0010, 0100, 1000, 0001; no requester is granted twice before all four are served.
- Input changes after grant: req[3] with S=2, E=5; at cycle 2 drop req[3] and change end_val[3] to 15 -> counts stop at 5; done[3] at cycle 6.
- Reset mid-run: assert reset_n=0 while in RUN with cnt_q=4 -> all outputs 0 immediately with no done pulse; after release, req=1001 grants 0001 first.
